// File: rtl/lcd_init_sequencer.sv
// rtl/lcd_init_sequencer.sv - replays a host-loaded init sequence (words, delays, end marker) to the lcd init port.
module lcd_init_sequencer #(
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8,
  parameter int DELAY_UNIT = 48000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [15:0]       i_wr_data,
  input  logic              i_start,
  output logic [8:0]        o_init_rom,
  output logic              o_init_rdy,
  input  logic              i_init_ack,
  output logic              o_init_done,
  output logic              o_busy,
  output logic              o_error
);

  localparam int PW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [PW-1:0] PRESC_RELOAD = PW'(DELAY_UNIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SEND, S_DELAY, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_raddr;
  logic [15:0]       r_mem [DEPTH];
  logic [15:0]       r_rd_data;
  logic              r_fetch_ph, w_fetch_ph_nxt;
  logic [8:0]        r_rom, w_rom_nxt;
  logic              r_error, w_error_nxt;
  logic [13:0]       r_ticks, w_ticks_nxt;
  logic [PW-1:0]     r_presc, w_presc_nxt;
  logic              w_adv;
  logic              w_busy;

  assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_busy      = w_busy;
  assign o_init_rdy  = (r_state == S_SEND);
  assign o_init_done = (r_state == S_DONE);
  assign o_init_rom  = r_rom;
  assign o_error     = r_error;

  // Read address is registered first, then the array read; FETCH therefore spans two cycles.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && !w_busy) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_raddr   <= r_addr;
    r_rd_data <= r_mem[r_raddr];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_fetch_ph <= 1'b0;
      r_rom      <= '0;
      r_error    <= 1'b0;
      r_ticks    <= '0;
      r_presc    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_fetch_ph <= w_fetch_ph_nxt;
      r_rom      <= w_rom_nxt;
      r_error    <= w_error_nxt;
      r_ticks    <= w_ticks_nxt;
      r_presc    <= w_presc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_fetch_ph_nxt = r_fetch_ph;
    w_rom_nxt      = r_rom;
    w_error_nxt    = r_error;
    w_ticks_nxt    = r_ticks;
    w_presc_nxt    = r_presc;
    w_adv          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt    = S_FETCH;
          w_addr_nxt     = '0;
          w_fetch_ph_nxt = 1'b0;
        end
      end
      S_FETCH: begin
        if (!r_fetch_ph) begin
          w_fetch_ph_nxt = 1'b1;
        end else begin
          w_fetch_ph_nxt = 1'b0;
          w_state_nxt    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (r_rd_data[15]) begin
          w_state_nxt = S_DONE;
        end else if (r_rd_data[14]) begin
          if (r_rd_data[13:0] == 14'd0) begin
            w_adv = 1'b1;
          end else begin
            w_ticks_nxt = r_rd_data[13:0];
            w_presc_nxt = PRESC_RELOAD;
            w_state_nxt = S_DELAY;
          end
        end else begin
          w_rom_nxt   = r_rd_data[8:0];
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (i_init_ack) begin
          w_adv = 1'b1;
        end
      end
      S_DELAY: begin
        if (r_presc == '0) begin
          if (r_ticks == 14'd1) begin
            w_adv = 1'b1;
          end else begin
            w_ticks_nxt = r_ticks - 14'd1;
            w_presc_nxt = PRESC_RELOAD;
          end
        end else begin
          w_presc_nxt = r_presc - PW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Running off the end of memory never wraps: it finishes with the error flag set.
    if (w_adv) begin
      if (r_addr == LAST_ADDR) begin
        w_state_nxt = S_DONE;
        w_error_nxt = 1'b1;
      end else begin
        w_addr_nxt     = r_addr + ADDR_W'(1);
        w_fetch_ph_nxt = 1'b0;
        w_state_nxt    = S_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// tb/tb_lcd_init_sequencer.sv - randomized self-checking bench for lcd_init_sequencer against an event-list model.
module tb_lcd_init_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DU    = 4;
  localparam int LIMIT = 3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [15:0]   i_wr_data;
  logic          i_start;
  logic [8:0]    o_init_rom;
  logic          o_init_rdy;
  logic          i_init_ack;
  logic          o_init_done;
  logic          o_busy;
  logic          o_error;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit is_done;
    int val;
    int gap;
    bit err;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] m [DEPTH];

  lcd_init_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .DELAY_UNIT(DU)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .i_start     (i_start),
    .o_init_rom  (o_init_rom),
    .o_init_rdy  (o_init_rdy),
    .i_init_ack  (i_init_ack),
    .o_init_done (o_init_done),
    .o_busy      (o_busy),
    .o_error     (o_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Gaps count clock edges from the reference edge (start sample or ack sample) to the visible event.
  // Each entry costs 3 edges to fetch and decode; a delay adds N*DU; walking past the end finishes at once.
  task automatic build_model();
    int  a;
    int  g;
    bit  fin;
    ev_t e;
    exp_q.delete();
    a = 0; g = 0; fin = 0;
    while (!fin) begin
      if (m[a][15]) begin
        e.is_done = 1; e.val = 0; e.gap = g + 3; e.err = 0;
        exp_q.push_back(e);
        fin = 1;
      end else begin
        g += 3;
        if (m[a][14]) begin
          g += int'(m[a][13:0]) * DU;
        end else begin
          e.is_done = 0; e.val = int'(m[a][8:0]); e.gap = g; e.err = 0;
          exp_q.push_back(e);
          g = 0;
        end
        if (a == DEPTH - 1) begin
          e.is_done = 1; e.val = 0; e.gap = g; e.err = 1;
          exp_q.push_back(e);
          fin = 1;
        end else begin
          a++;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_mem();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      i_wr_en   = 1'b1;
      i_wr_addr = AW'(a);
      i_wr_data = m[a];
    end
    @(negedge clk);
    i_wr_en = 1'b0;
  endtask

  task automatic play(input int hold_fix, input bit disturb, input bit reset_mid);
    int  t;
    int  h;
    int  bad;
    ev_t e;
    build_model();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    t = 0;
    check("busy_start", int'(o_busy), 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      while (!(o_init_rdy || o_init_done) && t < LIMIT) begin
        @(negedge clk);
        t++;
      end
      if (t >= LIMIT) begin
        check("timeout", 0, 1);
        return;
      end
      check(e.is_done ? "done_gap" : "word_gap", t, e.gap);
      check("event_kind", int'(o_init_done), int'(e.is_done));
      if (e.is_done) begin
        check("error_flag", int'(o_error), int'(e.err));
        check("busy_done", int'(o_busy), 0);
        check("rdy_done", int'(o_init_rdy), 0);
        repeat (3) @(negedge clk);
        check("done_sticky", int'(o_init_done), 1);
        return;
      end
      check("word", int'(o_init_rom), e.val);
      check("busy_send", int'(o_busy), 1);
      h = (hold_fix >= 0) ? hold_fix : int'($urandom_range(0, 4));
      bad = 0;
      for (int c = 0; c < h; c++) begin
        if (disturb && i == 0 && c == 0) begin
          i_start   = 1'b1;
          i_wr_en   = 1'b1;
          i_wr_addr = '0;
          i_wr_data = ~m[0];
        end
        @(negedge clk);
        i_start = 1'b0;
        i_wr_en = 1'b0;
        if (!(o_init_rdy === 1'b1 && int'(o_init_rom) == e.val)) bad++;
      end
      check("hold_stable", bad, 0);
      if (reset_mid) begin
        rst_n = 1'b0;
        #1;
        check("rst_rdy", int'(o_init_rdy), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_init_done), 0);
        check("rst_rom", int'(o_init_rom), 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      i_init_ack = 1'b1;
      @(negedge clk);
      i_init_ack = 1'b0;
      t = 0;
      check("rdy_drop", int'(o_init_rdy), 0);
    end
  endtask

  task automatic random_program();
    int r;
    for (int a = 0; a < DEPTH; a++) begin
      r = int'($urandom_range(0, 9));
      if (r >= 5 && r <= 7)  m[a] = {2'b01, 14'($urandom_range(0, 3))};
      else if (r == 8)       m[a] = {1'b1, 15'($urandom)};
      else                   m[a] = {2'b00, 14'($urandom)};
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    i_wr_en    = 1'b0;
    i_wr_addr  = '0;
    i_wr_data  = '0;
    i_start    = 1'b0;
    i_init_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdy", int'(o_init_rdy), 0);
    check("reset_busy", int'(o_busy), 0);
    check("reset_done", int'(o_init_done), 0);
    check("reset_error", int'(o_error), 0);
    check("reset_rom", int'(o_init_rom), 0);
    rst_n = 1'b1;

    // basic two-word sequence, then ack held off for 50 cycles on the same program
    for (int a = 0; a < DEPTH; a++) m[a] = 16'h8000;
    m[0] = 16'h0111; m[1] = 16'h0022;
    @(negedge clk);
    i_init_ack = 1'b1;
    @(negedge clk);
    i_init_ack = 1'b0;
    check("idle_ack_ignored", int'(o_busy), 0);
    write_mem();
    play(2, 0, 0);
    do_reset();
    play(50, 0, 0);

    // delays: 3 ticks then a zero-tick delay
    do_reset();
    for (int a = 0; a < DEPTH; a++) m[a] = 16'h8000;
    m[0] = 16'h4003; m[1] = 16'h4000; m[2] = 16'h0155;
    write_mem();
    play(-1, 0, 0);

    // no end marker: every entry sent, then error without wrap
    do_reset();
    for (int a = 0; a < DEPTH; a++) m[a] = {2'b00, 14'($urandom)};
    write_mem();
    play(-1, 0, 0);

    // write and start while busy are dropped; replay after reset shows original memory
    do_reset();
    for (int a = 0; a < DEPTH; a++) m[a] = 16'h8000;
    m[0] = 16'h0111; m[1] = 16'h0022;
    write_mem();
    play(3, 1, 0);
    do_reset();
    play(1, 0, 0);

    // reset in SEND, then replay from address 0
    do_reset();
    play(2, 0, 1);
    play(-1, 0, 0);

    for (int n = 0; n < 10; n++) begin
      do_reset();
      random_program();
      write_mem();
      play(-1, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_init_sequencer.md
Name: lcd_init_sequencer

Overview:
- Local init-ROM player for the LCD controller's init interface (9-bit word, rdy/ack, done).
- Holds a writable sequence memory, loaded by the host over the SPI decode path, and replays it on i_start.
- Supports inline delay commands and an end marker; drives init_done when the sequence completes.
- Sits between the SPI receive logic and the lcd module. It replaces direct SPI-to-lcd streaming, so the host no longer has to pace init words itself.

Parameters:
- DEPTH, 256: number of 16-bit sequence entries.
- ADDR_W, 8: address width; DEPTH = 2**ADDR_W.
- DELAY_UNIT, 48000: i_clk cycles per delay tick (1 ms at 48 MHz).

Ports:
- i_clk  in  1  system clock (48 MHz HFOSC).
- i_reset_n  in  1  asynchronous, active-low reset.
- i_wr_en  in  1  write strobe into sequence memory.
- i_wr_addr  in  ADDR_W  write address.
- i_wr_data  in  16  write data.
- i_start  in  1  single-cycle pulse; begins playback at address 0.
- o_init_rom  out  9  init word to lcd (bit8 = regsel, bits7:0 = data).
- o_init_rdy  out  1  o_init_rom valid.
- i_init_ack  in  1  lcd accepted the current word.
- o_init_done  out  1  sequence finished; sticky.
- o_busy  out  1  playback in progress.
- o_error  out  1  DEPTH exhausted without an end marker; sticky.

Behaviour:
- Entry format:
  - bit15 = 1: END.
  - else bit14 = 1: DELAY, bits13:0 = tick count N.
  - else WORD, bits8:0 sent; bits13:9 ignored.
- Reset (asynchronous, i_reset_n low):
  - State = IDLE, address = 0.
  - o_init_rom, o_init_rdy, o_init_done, o_busy and o_error all 0.
  - Memory contents are undefined after reset; reset does not clear them.
- Memory:
  - Synchronous read, 1-cycle latency.
  - Writes are accepted only when o_busy = 0; writes with o_busy = 1 are dropped.
- States: IDLE, FETCH, DECODE, SEND, DELAY, DONE.
- IDLE: on i_start = 1, go to FETCH, addr = 0, o_busy = 1. i_start in any other state is ignored.
- FETCH: present addr to memory; go to DECODE.
- DECODE: read data is valid here.
  - END: go to DONE.
  - DELAY with N = 0: addr advances immediately (see end-of-memory rule).
  - DELAY with N > 0: load tick counter = N and prescaler = DELAY_UNIT-1; go to DELAY.
  - WORD: o_init_rom = bits8:0, o_init_rdy = 1; go to SEND.
- SEND:
  - o_init_rdy and o_init_rom are held stable until i_init_ack is sampled high.
  - On that edge o_init_rdy goes 0 and addr advances.
  - i_init_ack while o_init_rdy = 0 is ignored.
- DELAY:
  - Prescaler decrements every cycle.
  - At prescaler 0: reload the prescaler and decrement the tick counter.
  - When the tick counter reaches 0: advance addr.
  - Total wait is exactly N*DELAY_UNIT cycles in DELAY.
- Advance rule:
  - addr < DEPTH-1: addr + 1, go to FETCH.
  - addr == DEPTH-1: no wrap; go to DONE and set o_error = 1.
- DONE:
  - o_init_done = 1, o_busy = 0, o_init_rdy = 0.
  - Terminal until reset; i_start is ignored.
- Latency:
  - i_start sampled high at edge 0 → FETCH after edge 1, DECODE after edge 2, o_init_rdy = 1 after edge 3.
  - Ack sampled at edge k → next WORD's o_init_rdy = 1 after edge k+3.
  - DECODE of END at edge j → o_init_done = 1 after edge j+1.
- Reset mid-operation (SEND or DELAY): all outputs return to reset values immediately; the lcd sees rdy drop without ack.

Test Plan:
- Load [0x0111, 0x0022, 0x8000], pulse i_start, ack each word 2 cycles after rdy → words 0x111 then 0x022 presented in order; rdy first high 3 cycles after start; o_init_done = 1, o_error = 0, o_busy = 0.
- Hold i_init_ack low 50 cycles on the first word → o_init_rom stays 0x111 and o_init_rdy stays 1 throughout; no address advance.
- DELAY_UNIT = 4, entries [0x4003, 0x0155, 0x8000] → exactly 12 cycles in DELAY, then 0x155 presented; DELAY with N = 0 advances with no wait.
- DEPTH = 4 with all entries WORD, no END → 4 words sent, then o_init_done = 1 and o_error = 1; address does not wrap.
- i_wr_en during playback and i_start while busy → memory unchanged on a later replay-after-reset readback; no restart.
- Assert i_reset_n low during SEND → o_init_rdy, o_busy and o_init_done are 0 the same cycle; a subsequent i_start replays from address 0.
